// File: rtl/reset_sequencer.sv
// Staged release of per-subsystem active-low resets, one stage at a time in index order.
// Each stage waits DELAY cycles, then must acknowledge within TIMEOUT cycles or all stages fall back into reset.
module reset_sequencer #(
  parameter int STAGES  = 4,
  parameter int DELAY   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             restart,
  input  logic [STAGES-1:0]                                stage_ready,
  output logic [STAGES-1:0]                                stage_resetn,
  output logic                                             done,
  output logic                                             fault,
  output logic [((STAGES > 1) ? $clog2(STAGES) : 1)-1:0]   fault_stage
);

  localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] DLY_LAST = DW'(DELAY - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(STAGES - 1);

  typedef enum logic [1:0] {
    ST_DELAY,
    ST_WAIT,
    ST_DONE,
    ST_FAULT
  } state_e;

  state_e              state_q;
  logic [IW-1:0]       idx_q;
  logic [DW-1:0]       dcnt_q;
  logic [TW-1:0]       tcnt_q;
  logic [STAGES-1:0]   resetn_q;
  logic                done_q;
  logic                fault_q;
  logic [IW-1:0]       fstage_q;

  // stage_ready may come from another clock domain
  logic [STAGES-1:0]   sync1_q;
  logic [STAGES-1:0]   rdy_q;

  logic                rdy_cur;
  logic                all_rdy;
  logic [IW-1:0]       first_low;

  function automatic logic [IW-1:0] lowest_low(input logic [STAGES-1:0] v);
    lowest_low = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (!v[k]) lowest_low = IW'(k);
    end
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      rdy_q   <= '0;
    end else begin
      sync1_q <= stage_ready;
      rdy_q   <= sync1_q;
    end
  end

  assign rdy_cur   = rdy_q[idx_q];
  assign all_rdy   = &rdy_q;
  assign first_low = lowest_low(rdy_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_DELAY;
      idx_q    <= '0;
      dcnt_q   <= '0;
      tcnt_q   <= '0;
      resetn_q <= '0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      fstage_q <= '0;
    end else begin
      case (state_q)
        ST_DELAY: begin
          if (dcnt_q == DLY_LAST) begin
            resetn_q[idx_q] <= 1'b1;
            tcnt_q          <= '0;
            state_q         <= ST_WAIT;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        ST_WAIT: begin
          // an acknowledge on the timeout edge still counts
          if (rdy_cur) begin
            if (idx_q == IDX_LAST) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + IW'(1);
              dcnt_q  <= '0;
              state_q <= ST_DELAY;
            end
          end else if (tcnt_q == TMO_LAST) begin
            resetn_q <= '0;
            done_q   <= 1'b0;
            fault_q  <= 1'b1;
            fstage_q <= idx_q;
            state_q  <= ST_FAULT;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        ST_DONE: begin
          if (!all_rdy) begin
            resetn_q <= '0;
            done_q   <= 1'b0;
            fault_q  <= 1'b1;
            fstage_q <= first_low;
            state_q  <= ST_FAULT;
          end
        end
        ST_FAULT: begin
          // fault_stage is left intact so software can read the cause after restart
          if (restart) begin
            fault_q <= 1'b0;
            idx_q   <= '0;
            dcnt_q  <= '0;
            state_q <= ST_DELAY;
          end
        end
        default: state_q <= ST_DELAY;
      endcase
    end
  end

  assign stage_resetn = resetn_q;
  assign done         = done_q;
  assign fault        = fault_q;
  assign fault_stage  = fstage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with STAGES=3, DELAY=4, TIMEOUT=8.
module tb_reset_sequencer;

  logic       clock;
  logic       reset;
  logic       restart;
  logic [2:0] stage_ready;
  logic [2:0] stage_resetn;
  logic       done;
  logic       fault;
  logic [1:0] fault_stage;

  int n_cmp;
  int n_err;

  reset_sequencer #(
    .STAGES (3),
    .DELAY  (4),
    .TIMEOUT(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .restart     (restart),
    .stage_ready (stage_ready),
    .stage_resetn(stage_resetn),
    .done        (done),
    .fault       (fault),
    .fault_stage (fault_stage)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance n rising edges, then settle just past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // leaves the bench one cycle before edge 1
  task automatic apply_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] rn, input logic d,
                          input logic f, input logic [1:0] fs);
    chk({tag, ".resetn"}, 32'(stage_resetn), 32'(rn));
    chk({tag, ".done"},   32'(done),         32'(d));
    chk({tag, ".fault"},  32'(fault),        32'(f));
    chk({tag, ".fstage"}, 32'(fault_stage),  32'(fs));
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    restart     = 1'b0;
    stage_ready = 3'b111;

    // normal sequence
    apply_reset();
    chk_outs("rst", 3'b000, 1'b0, 1'b0, 2'd0);
    tick(3);
    chk("norm.e3", 32'(stage_resetn), 32'h0);
    tick(1);
    chk("norm.e4", 32'(stage_resetn), 32'h1);
    tick(4);
    chk("norm.e8", 32'(stage_resetn), 32'h1);
    tick(1);
    chk("norm.e9", 32'(stage_resetn), 32'h3);
    tick(5);
    chk_outs("norm.e14", 3'b111, 1'b0, 1'b0, 2'd0);
    tick(1);
    chk_outs("norm.e15", 3'b111, 1'b1, 1'b0, 2'd0);

    // stage 1 never acknowledges
    stage_ready = 3'b101;
    apply_reset();
    tick(9);
    chk("tmo.e9", 32'(stage_resetn), 32'h3);
    tick(7);
    chk_outs("tmo.e16", 3'b011, 1'b0, 1'b0, 2'd0);
    tick(1);
    chk_outs("tmo.e17", 3'b000, 1'b0, 1'b1, 2'd1);
    tick(3);
    chk_outs("tmo.hold", 3'b000, 1'b0, 1'b1, 2'd1);

    // restart out of the timeout fault
    stage_ready = 3'b111;
    tick(3);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk_outs("rs.R", 3'b000, 1'b0, 1'b0, 2'd1);
    tick(4);
    chk("rs.R4", 32'(stage_resetn), 32'h1);
    tick(10);
    chk_outs("rs.R14", 3'b111, 1'b0, 1'b0, 2'd1);
    tick(1);
    chk_outs("rs.R15", 3'b111, 1'b1, 1'b0, 2'd1);

    // restart is ignored in DONE
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(2);
    chk_outs("rs.done", 3'b111, 1'b1, 1'b0, 2'd1);

    // lost acknowledge on stage 2 while in DONE
    stage_ready = 3'b011;
    tick(1);
    stage_ready = 3'b111;
    tick(1);
    chk_outs("lost.k1", 3'b111, 1'b1, 1'b0, 2'd1);
    tick(1);
    chk_outs("lost.k2", 3'b000, 1'b0, 1'b1, 2'd2);

    // reset while stage 1 sits in WAIT
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(9);
    chk_outs("mid.wait", 3'b011, 1'b0, 1'b0, 2'd2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_outs("mid.rst", 3'b000, 1'b0, 1'b0, 2'd0);
    tick(3);
    chk("mid.e3", 32'(stage_resetn), 32'h0);
    tick(1);
    chk("mid.e4", 32'(stage_resetn), 32'h1);
    tick(5);
    chk("mid.e9", 32'(stage_resetn), 32'h3);
    tick(5);
    chk_outs("mid.e14", 3'b111, 1'b0, 1'b0, 2'd0);
    tick(1);
    chk_outs("mid.e15", 3'b111, 1'b1, 1'b0, 2'd0);

    // stage 1 acknowledge lands on the timeout edge
    stage_ready = 3'b101;
    apply_reset();
    tick(14);
    stage_ready = 3'b111;
    tick(2);
    chk_outs("tie.e16", 3'b011, 1'b0, 1'b0, 2'd0);
    tick(1);
    chk_outs("tie.e17", 3'b011, 1'b0, 1'b0, 2'd0);
    tick(3);
    chk("tie.e20", 32'(stage_resetn), 32'h3);
    tick(1);
    chk_outs("tie.e21", 3'b111, 1'b0, 1'b0, 2'd0);
    tick(1);
    chk_outs("tie.e22", 3'b111, 1'b1, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
